// File: rtl/accum_bank_pkg.sv
// Shared configuration for the output-accumulator bank: array geometry defaults
// and the per-column control word that travels down the skew register.
package accum_bank_pkg;

  localparam int sys_cols   = 4;
  localparam int P_BITWIDTH = 16;

  // Row field is sized for the deepest supported tile (256 rows); lanes use the low ROW_W bits.
  localparam int ROW_MAX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [ROW_MAX_W-1:0] row;
  } acc_ctrl_t;

endpackage

// File: rtl/accum_column.sv
// One accumulator lane: per-row partial-sum buffer with sticky overflow bit,
// single-cycle read-modify-write and registered emission of the final value.
module accum_column
  import accum_bank_pkg::*;
#(
  parameter int IN_W     = P_BITWIDTH,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 16,
  parameter bit SATURATE = 1'b1,
  parameter int ROW_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  acc_ctrl_t        ctrl_i,
  input  logic [IN_W-1:0]  data_i,
  output logic             valid_o,
  output logic [ROW_W-1:0] row_o,
  output logic [ACC_W-1:0] data_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Entry layout: {sticky overflow, accumulated value}.
  logic [ACC_W:0]   buf_q [DEPTH];
  logic [ACC_W:0]   rd_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] x_ext_s;
  logic [ACC_W-1:0] res_s;
  logic             ovf_s;
  logic             res_ovf_s;
  logic             emit_s;

  logic             valid_q, valid_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  assign x_ext_s = ACC_W'($signed(data_i));

  always_comb begin
    rd_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_s = (ctrl_i.row == ROW_MAX_W'(i)) ? buf_q[i] : rd_s;
    end
  end

  // The ACC_W+1-bit sum overflows when its top two bits disagree.
  always_comb begin
    sum_s     = {rd_s[ACC_W-1], rd_s[ACC_W-1:0]} + {x_ext_s[ACC_W-1], x_ext_s};
    ovf_s     = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    res_s     = sum_s[ACC_W-1:0];
    res_ovf_s = rd_s[ACC_W] | ovf_s;
    if (ctrl_i.first) begin
      res_s     = x_ext_s;
      res_ovf_s = 1'b0;
    end else if (ovf_s && SATURATE) begin
      res_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      res_s = sum_s[ACC_W-1:0];
    end
  end

  always_comb begin
    emit_s  = ctrl_i.valid & ctrl_i.last;
    valid_d = emit_s;
    row_d   = emit_s ? ctrl_i.row[ROW_W-1:0] : row_q;
    data_d  = emit_s ? res_s : data_q;
    ovf_d   = emit_s ? res_ovf_s : ovf_q;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ctrl_i.valid && (ctrl_i.row == ROW_MAX_W'(i))) begin
        buf_q[i] <= {res_ovf_s, res_s};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign row_o   = row_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/accum_bank.sv
// Output-accumulator bank: row counter, per-column control skew matching the
// array's diagonal data skew, and COLS accumulator lanes.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int COLS     = sys_cols,
  parameter int IN_W     = P_BITWIDTH,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 16,
  parameter bit SATURATE = 1'b1,
  localparam int ROW_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [COLS*IN_W-1:0]  i_data,
  output logic [COLS-1:0]       o_valid,
  output logic [COLS*ROW_W-1:0] o_row,
  output logic [COLS*ACC_W-1:0] o_data,
  output logic [COLS-1:0]       o_ovf,
  output logic                  o_tile_done
);

  logic [ROW_MAX_W-1:0] row_q, row_d;
  logic                 done_q, done_d;
  acc_ctrl_t            head_s;
  acc_ctrl_t            ctrl_s [COLS];

  always_comb begin
    if (!i_valid) begin
      row_d = row_q;
    end else if (row_q == ROW_MAX_W'(DEPTH-1)) begin
      row_d = '0;
    end else begin
      row_d = row_q + ROW_MAX_W'(1);
    end
  end

  always_comb begin
    head_s.valid = i_valid;
    head_s.first = i_first;
    head_s.last  = i_last;
    head_s.row   = row_q;
    done_d = ctrl_s[COLS-1].valid && ctrl_s[COLS-1].last &&
             (ctrl_s[COLS-1].row == ROW_MAX_W'(DEPTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      done_q <= done_d;
    end
  end

  assign o_tile_done = done_q;

  // Column c sees the column-0 control word c cycles later, in step with its data.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    if (c == 0) begin : g_head
      assign ctrl_s[0] = head_s;
    end else begin : g_skew
      acc_ctrl_t ctrl_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctrl_q <= '0;
        end else begin
          ctrl_q <= ctrl_s[c-1];
        end
      end
      assign ctrl_s[c] = ctrl_q;
    end

    accum_column #(
      .IN_W    (IN_W),
      .ACC_W   (ACC_W),
      .DEPTH   (DEPTH),
      .SATURATE(SATURATE),
      .ROW_W   (ROW_W)
    ) u_col (
      .clk    (clk),
      .rst    (rst),
      .ctrl_i (ctrl_s[c]),
      .data_i (i_data[c*IN_W +: IN_W]),
      .valid_o(o_valid[c]),
      .row_o  (o_row[c*ROW_W +: ROW_W]),
      .data_o (o_data[c*ACC_W +: ACC_W]),
      .ovf_o  (o_ovf[c])
    );
  end

endmodule

// File: tb/tb_accum_bank.sv
// Randomized bench for accum_bank: a saturating and a wrapping instance share
// stimulus and are scored against an arithmetic model of the tile accumulation.
module tb_accum_bank;

  localparam int COLS  = 4;
  localparam int IN_W  = 16;
  localparam int ACC_W = 20;
  localparam int DEPTH = 4;
  localparam int ROW_W = 2;
  localparam int HN    = 16384;
  localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 64'sd1;
  localparam longint AMIN = -(longint'(1) << (ACC_W-1));

  logic                  clk, rst, i_valid, i_first, i_last;
  logic [COLS*IN_W-1:0]  i_data;
  logic [COLS-1:0]       ov_s, ov_w, of_s, of_w;
  logic [COLS*ROW_W-1:0] or_s, or_w;
  logic [COLS*ACC_W-1:0] od_s, od_w;
  logic                  td_s, td_w;

  accum_bank #(.COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last), .i_data(i_data),
    .o_valid(ov_s), .o_row(or_s), .o_data(od_s), .o_ovf(of_s), .o_tile_done(td_s));

  accum_bank #(.COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last), .i_data(i_data),
    .o_valid(ov_w), .o_row(or_w), .o_data(od_w), .o_ovf(of_w), .o_tile_done(td_w));

  typedef struct {
    int     due;
    int     row;
    longint d_sat;
    bit     f_sat;
    longint d_wrp;
    bit     f_wrp;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  bit     started = 1'b0;
  int     td_seen = 0;
  int     m_row = 0;
  int     cur_vals [COLS];
  int     t1_vals [COLS];
  bit     hist_valid [HN];
  int     hist_data [HN][COLS];
  longint acc_sat [COLS][DEPTH];
  bit     ovf_sat [COLS][DEPTH];
  longint acc_wrp [COLS][DEPTH];
  bit     ovf_wrp [COLS][DEPTH];
  exp_t   exp_q [COLS][$];
  int     td_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint s);
    longint m;
    m = s & ((longint'(1) << ACC_W) - 64'sd1);
    if (m > AMAX) m = m - (longint'(1) << ACC_W);
    return m;
  endfunction

  // Model: every lane of a beat is folded in at once; emissions are due c+1 cycles later.
  task automatic model_beat(input bit f, input bit l);
    longint x, s;
    bit     of;
    exp_t   e;
    for (int c = 0; c < COLS; c++) begin
      x = longint'(cur_vals[c]);
      if (f) begin
        acc_sat[c][m_row] = x; ovf_sat[c][m_row] = 1'b0;
        acc_wrp[c][m_row] = x; ovf_wrp[c][m_row] = 1'b0;
      end else begin
        s  = acc_sat[c][m_row] + x;
        of = (s > AMAX) || (s < AMIN);
        acc_sat[c][m_row] = (s > AMAX) ? AMAX : ((s < AMIN) ? AMIN : s);
        ovf_sat[c][m_row] = ovf_sat[c][m_row] | of;
        s  = acc_wrp[c][m_row] + x;
        of = (s > AMAX) || (s < AMIN);
        acc_wrp[c][m_row] = wrap_acc(s);
        ovf_wrp[c][m_row] = ovf_wrp[c][m_row] | of;
      end
      if (l) begin
        e.due = cyc + c + 1; e.row = m_row;
        e.d_sat = acc_sat[c][m_row]; e.f_sat = ovf_sat[c][m_row];
        e.d_wrp = acc_wrp[c][m_row]; e.f_wrp = ovf_wrp[c][m_row];
        exp_q[c].push_back(e);
      end
    end
    if (l && (m_row == DEPTH-1)) td_q.push_back(cyc + COLS);
    m_row = (m_row + 1) % DEPTH;
  endtask

  // One clock of stimulus; lane c carries the data of the beat issued c cycles earlier.
  task automatic drive_cycle(input bit v, input bit f, input bit l);
    int idx, src;
    @(posedge clk);
    #1;
    idx = cyc % HN;
    hist_valid[idx] = v;
    for (int c = 0; c < COLS; c++) hist_data[idx][c] = cur_vals[c];
    i_valid = v;
    i_first = v ? f : 1'($urandom);
    i_last  = v ? l : 1'($urandom);
    for (int c = 0; c < COLS; c++) begin
      src = cyc - c;
      if (src >= 0 && hist_valid[src % HN])
        i_data[c*IN_W +: IN_W] = IN_W'(hist_data[src % HN][c]);
      else
        i_data[c*IN_W +: IN_W] = IN_W'($urandom);
    end
    if (v && !rst) model_beat(f, l);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < COLS; c++) cur_vals[c] = int'($urandom_range(0, 65535)) - 32768;
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  // mode 0: random values, 1: fixv on every lane, 2: per-lane table t1_vals.
  task automatic run_pass(input bit f, input bit l, input int mode, input int fixv, input int gap_pct);
    for (int r = 0; r < DEPTH; r++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) idle(1);
      for (int c = 0; c < COLS; c++) begin
        if (mode == 1) cur_vals[c] = fixv;
        else if (mode == 2) cur_vals[c] = t1_vals[c];
        else cur_vals[c] = int'($urandom_range(0, 65535)) - 32768;
      end
      drive_cycle(1'b1, f, l);
    end
  endtask

  task automatic run_tile(input int npass, input int mode, input int fixv, input int gap_pct);
    for (int p = 0; p < npass; p++) run_pass(p == 0, p == npass-1, mode, fixv, gap_pct);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, longint'(ov_s) | longint'(ov_w), 0);
    check_val({tag, "_ovf"}, longint'(of_s) | longint'(of_w), 0);
    check_val({tag, "_row"}, longint'(or_s) | longint'(or_w), 0);
    check_val({tag, "_done"}, longint'(td_s) | longint'(td_w), 0);
    for (int c = 0; c < COLS; c++) begin
      check_val({tag, "_data_sat"}, longint'(od_s[c*ACC_W +: ACC_W]), 0);
      check_val({tag, "_data_wrp"}, longint'(od_w[c*ACC_W +: ACC_W]), 0);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int c = 0; c < COLS; c++) begin
        bit   due;
        exp_t e;
        due = (exp_q[c].size() > 0) && (exp_q[c][0].due == cyc);
        check_val("valid_sat", longint'(ov_s[c]), longint'(due));
        check_val("valid_wrp", longint'(ov_w[c]), longint'(due));
        if (due) begin
          e = exp_q[c].pop_front();
          check_val("row_sat", longint'(or_s[c*ROW_W +: ROW_W]), longint'(e.row));
          check_val("row_wrp", longint'(or_w[c*ROW_W +: ROW_W]), longint'(e.row));
          check_val("data_sat", longint'($signed(od_s[c*ACC_W +: ACC_W])), e.d_sat);
          check_val("data_wrp", longint'($signed(od_w[c*ACC_W +: ACC_W])), e.d_wrp);
          check_val("ovf_sat", longint'(of_s[c]), longint'(e.f_sat));
          check_val("ovf_wrp", longint'(of_w[c]), longint'(e.f_wrp));
        end
      end
      begin
        bit tdue;
        tdue = (td_q.size() > 0) && (td_q[0] == cyc);
        check_val("tile_done_sat", longint'(td_s), longint'(tdue));
        check_val("tile_done_wrp", longint'(td_w), longint'(tdue));
        if (tdue) void'(td_q.pop_front());
      end
      if (td_s) td_seen++;
    end
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_data = '0;
    for (int c = 0; c < COLS; c++) cur_vals[c] = 0;
    t1_vals[0] = 3; t1_vals[1] = -2; t1_vals[2] = 7; t1_vals[3] = -32768;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    run_tile(1, 2, 0, 0);                        // single first+last pass
    run_tile(1, 2, 0, 0);                        // same again, back-to-back
    run_pass(1'b1, 1'b0, 1, 1, 0);               // three passes: 1 + 2 + 3
    run_pass(1'b0, 1'b0, 1, 2, 0);
    run_pass(1'b0, 1'b1, 1, 3, 0);
    run_tile(17, 1, 32767, 0);                   // positive overflow
    run_tile(17, 1, -32768, 10);                 // negative overflow
    run_tile(2, 0, 0, 0);                        // non-overflowing tile right after
    idle(COLS + 2);

    td_seen = 0;
    run_tile(1, 1, 5, 40);                       // tile A
    run_tile(2, 1, 1, 40);                       // tile B, no forced gap
    idle(COLS + 2);
    check_val("tile_done_pulses", longint'(td_seen), 2);

    run_pass(1'b1, 1'b0, 1, 7, 0);               // reset in the middle of pass 2
    cur_vals = '{7, 7, 7, 7};
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    for (int c = 0; c < COLS; c++) exp_q[c].delete();
    td_q.delete();
    m_row = 0;
    idle(2);
    rst = 1'b0;
    run_tile(2, 1, 4, 0);                        // 4 + 4 after reset

    for (int t = 0; t < 30; t++) begin
      run_tile(int'($urandom_range(1, 4)), 0, 0, int'($urandom_range(0, 40)));
    end
    idle(COLS + 3);
    for (int c = 0; c < COLS; c++) check_val("drain_lane", longint'(exp_q[c].size()), 0);
    check_val("drain_tile_done", longint'(td_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
